// File: rtl/ap_ctrl_driver.sv
// ---------------------------------------------------------------------------
// ap_ctrl_driver
//   Drives an HLS core through its ap_ctrl_hs / ap_ctrl_chain handshake for a
//   batch of cmd_num transactions, and collects simple performance statistics
//   for the batch. An idle-cycle watchdog parks the block in an error state if
//   the core stops responding. Software leaves that state with 'clear'.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-low reset (deassertion synchronised)
//   cmd_valid     request to run a batch
//   cmd_num       number of transactions in the batch
//   cmd_ready     high when a batch can be accepted (IDLE)
//   ap_start      start to the core
//   ap_continue   continue to the core
//   ap_ready      core accepted inputs
//   ap_done       core completed a transaction
//   busy          batch in progress
//   started_cnt   number of ap_start & ap_ready handshakes
//   done_cnt      number of counted ap_done pulses (saturates at cmd_num)
//   first_lat     cycles from accept to the first ap_done
//   last_ii       cycles between the two most recent ready handshakes
//   total_cycles  cycles from accept to the final ap_done
//   finish        one-cycle pulse at batch end (success or timeout)
//   error         sticky watchdog timeout flag
//   clear         synchronous clear of error, returns ERR to IDLE
// ---------------------------------------------------------------------------
module ap_ctrl_driver #(
    parameter int CNT_W   = 32,
    parameter int NUM_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [NUM_W-1:0] cmd_num,
    output logic             cmd_ready,
    output logic             ap_start,
    output logic             ap_continue,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             busy,
    output logic [NUM_W-1:0] started_cnt,
    output logic [NUM_W-1:0] done_cnt,
    output logic [CNT_W-1:0] first_lat,
    output logic [CNT_W-1:0] last_ii,
    output logic [CNT_W-1:0] total_cycles,
    output logic             finish,
    output logic             error,
    input  logic             clear
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Unsigned increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Reset synchroniser
    logic [1:0] rst_sync_r;
    logic       rst_int_n_s;

    // FSM
    state_t state_r;
    state_t state_nxt_s;

    // Batch bookkeeping
    logic [NUM_W-1:0] num_r;
    logic [NUM_W-1:0] started_r;
    logic [NUM_W-1:0] done_r;
    logic [CNT_W-1:0] tc_r;
    logic [CNT_W-1:0] first_lat_r;
    logic [CNT_W-1:0] last_ii_r;
    logic [CNT_W-1:0] last_hs_r;
    logic [WD_W-1:0]  wd_r;

    // Registered outputs
    logic cmd_ready_r;
    logic ap_start_r;
    logic ap_continue_r;
    logic busy_r;
    logic finish_r;
    logic error_r;

    // Combinational helpers
    logic             active_s;
    logic             accept_s;
    logic             zero_cmd_s;
    logic             hs_s;
    logic             done_evt_s;
    logic             wd_hit_s;
    logic [NUM_W-1:0] started_nxt_s;
    logic [NUM_W-1:0] done_nxt_s;
    logic [CNT_W-1:0] tc_inc_s;
    logic             cmd_ready_nxt_s;
    logic             ap_start_nxt_s;
    logic             ap_continue_nxt_s;
    logic             busy_nxt_s;
    logic             finish_nxt_s;
    logic             error_nxt_s;

    // Assertion is asynchronous; release ripples through two flops so the
    // core logic leaves reset cleanly on a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    assign active_s      = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign accept_s      = (state_r == ST_IDLE) && cmd_valid;
    assign zero_cmd_s    = (cmd_num == {NUM_W{1'b0}});
    // ap_start_r is only ever high in RUN, so this is a RUN-only handshake.
    assign hs_s          = ap_start_r && ap_ready;
    // Dones past the latched count are dropped so done_cnt saturates at num.
    assign done_evt_s    = active_s && ap_done && (done_r < num_r);
    assign started_nxt_s = hs_s ? started_r + NUM_W'(1) : started_r;
    assign done_nxt_s    = done_evt_s ? done_r + NUM_W'(1) : done_r;
    assign tc_inc_s      = sat_inc(tc_r);
    // Any ap_done (even an ignored surplus one) counts as core activity.
    assign wd_hit_s      = active_s && !hs_s && !ap_done &&
                           (wd_r == WD_W'(TIMEOUT - 1));

    // Next-state and next-output decode; outputs follow the next state so
    // they can be registered without an extra cycle of lag.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !zero_cmd_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (done_nxt_s == num_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (wd_hit_s) begin
                    state_nxt_s = ST_ERR;
                end else if (started_nxt_s == num_r) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (done_nxt_s == num_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (wd_hit_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_ERR: begin
                if (clear) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        cmd_ready_nxt_s   = (state_nxt_s == ST_IDLE);
        ap_continue_nxt_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
        busy_nxt_s        = ap_continue_nxt_s;
        error_nxt_s       = (state_nxt_s == ST_ERR);
        // On accept the started count restarts from zero, so start is owed.
        if (state_nxt_s != ST_RUN) begin
            ap_start_nxt_s = 1'b0;
        end else if (accept_s) begin
            ap_start_nxt_s = 1'b1;
        end else begin
            ap_start_nxt_s = (started_nxt_s < num_r);
        end
        // Pulse on zero-length accept, normal completion, or watchdog entry.
        finish_nxt_s = (accept_s && zero_cmd_s) ||
                       (active_s && (state_nxt_s == ST_IDLE)) ||
                       (active_s && (state_nxt_s == ST_ERR));
    end

    // FSM state register.
    always_ff @(posedge clock or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            cmd_ready_r   <= 1'b1;
            ap_start_r    <= 1'b0;
            ap_continue_r <= 1'b0;
            busy_r        <= 1'b0;
            finish_r      <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            cmd_ready_r   <= cmd_ready_nxt_s;
            ap_start_r    <= ap_start_nxt_s;
            ap_continue_r <= ap_continue_nxt_s;
            busy_r        <= busy_nxt_s;
            finish_r      <= finish_nxt_s;
            error_r       <= error_nxt_s;
        end
    end

    // Batch counters, statistics and watchdog. Everything freezes outside
    // RUN/DRAIN so results stay readable until the next accept.
    always_ff @(posedge clock or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            num_r       <= {NUM_W{1'b0}};
            started_r   <= {NUM_W{1'b0}};
            done_r      <= {NUM_W{1'b0}};
            tc_r        <= {CNT_W{1'b0}};
            first_lat_r <= {CNT_W{1'b0}};
            last_ii_r   <= {CNT_W{1'b0}};
            last_hs_r   <= {CNT_W{1'b0}};
            wd_r        <= {WD_W{1'b0}};
        end else if (accept_s) begin
            num_r       <= cmd_num;
            started_r   <= {NUM_W{1'b0}};
            done_r      <= {NUM_W{1'b0}};
            tc_r        <= {CNT_W{1'b0}};
            first_lat_r <= {CNT_W{1'b0}};
            last_ii_r   <= {CNT_W{1'b0}};
            last_hs_r   <= {CNT_W{1'b0}};
            wd_r        <= {WD_W{1'b0}};
        end else if (active_s) begin
            started_r <= started_nxt_s;
            done_r    <= done_nxt_s;
            tc_r      <= tc_inc_s;
            if (hs_s || ap_done) begin
                wd_r <= {WD_W{1'b0}};
            end else begin
                wd_r <= wd_r + WD_W'(1);
            end
            // tc_inc_s is the cycle index of this edge, counting accept as 0.
            if (done_evt_s && (done_r == {NUM_W{1'b0}})) begin
                first_lat_r <= tc_inc_s;
            end else begin
                first_lat_r <= first_lat_r;
            end
            if (hs_s) begin
                last_hs_r <= tc_inc_s;
                if (started_r != {NUM_W{1'b0}}) begin
                    last_ii_r <= tc_inc_s - last_hs_r;
                end else begin
                    last_ii_r <= last_ii_r;
                end
            end else begin
                last_hs_r <= last_hs_r;
                last_ii_r <= last_ii_r;
            end
        end else begin
            num_r       <= num_r;
            started_r   <= started_r;
            done_r      <= done_r;
            tc_r        <= tc_r;
            first_lat_r <= first_lat_r;
            last_ii_r   <= last_ii_r;
            last_hs_r   <= last_hs_r;
            wd_r        <= wd_r;
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign ap_start     = ap_start_r;
    assign ap_continue  = ap_continue_r;
    assign busy         = busy_r;
    assign finish       = finish_r;
    assign error        = error_r;
    assign started_cnt  = started_r;
    assign done_cnt     = done_r;
    assign first_lat    = first_lat_r;
    assign last_ii      = last_ii_r;
    assign total_cycles = tc_r;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// ---------------------------------------------------------------------------
// tb_ap_ctrl_driver
//   Directed bench for ap_ctrl_driver. Inputs change and outputs are sampled
//   on the falling clock edge; index k counts rising edges after the accept
//   edge (k=0). Expected values are worked out by hand from the cycle plan
//   of each scenario.
// ---------------------------------------------------------------------------
module tb_ap_ctrl_driver;

    localparam int CNT_W   = 32;
    localparam int NUM_W   = 16;
    localparam int TIMEOUT = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [NUM_W-1:0] cmd_num = 16'd0;
    logic             cmd_ready;
    logic             ap_start;
    logic             ap_continue;
    logic             ap_ready = 1'b0;
    logic             ap_done = 1'b0;
    logic             busy;
    logic [NUM_W-1:0] started_cnt;
    logic [NUM_W-1:0] done_cnt;
    logic [CNT_W-1:0] first_lat;
    logic [CNT_W-1:0] last_ii;
    logic [CNT_W-1:0] total_cycles;
    logic             finish;
    logic             error;
    logic             clear = 1'b0;

    int total_cnt = 0;
    int bad_cnt   = 0;

    int start_hi;
    int fin_cnt;
    int fin_k;

    ap_ctrl_driver #(
        .CNT_W   (CNT_W),
        .NUM_W   (NUM_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_num      (cmd_num),
        .cmd_ready    (cmd_ready),
        .ap_start     (ap_start),
        .ap_continue  (ap_continue),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .busy         (busy),
        .started_cnt  (started_cnt),
        .done_cnt     (done_cnt),
        .first_lat    (first_lat),
        .last_ii      (last_ii),
        .total_cycles (total_cycles),
        .finish       (finish),
        .error        (error),
        .clear        (clear)
    );

    // 10-unit clock period.
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Accepts a batch, then plays rdy_mask/dn_mask bit k onto ap_ready/ap_done
    // for edge k. At edge cv_k a stray cmd_valid (num=2) is offered while busy.
    task automatic run_batch(input logic [NUM_W-1:0] num, input logic [63:0] rdy_mask,
                             input logic [63:0] dn_mask, input int ncyc, input int cv_k,
                             output int s_hi, output int f_cnt, output int f_k);
        s_hi  = 0;
        f_cnt = 0;
        f_k   = -1;
        cmd_valid = 1'b1;
        cmd_num   = num;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_num   = 16'd0;
        if (ap_start) s_hi++;
        if (finish) begin
            f_cnt++;
            f_k = 0;
        end
        for (int k = 1; k <= ncyc; k++) begin
            ap_ready  = rdy_mask[k];
            ap_done   = dn_mask[k];
            cmd_valid = (k == cv_k);
            cmd_num   = (k == cv_k) ? 16'd2 : 16'd0;
            @(negedge clock);
            if (ap_start) s_hi++;
            if (finish) begin
                f_cnt++;
                f_k = k;
            end
        end
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        cmd_valid = 1'b0;
        cmd_num   = 16'd0;
    endtask

    initial begin
        // Power-on reset held across several edges.
        repeat (3) @(negedge clock);
        chk_eq("rst_cmd_ready", cmd_ready, 1);
        chk_eq("rst_ap_start", ap_start, 0);
        chk_eq("rst_ap_continue", ap_continue, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_finish", finish, 0);
        chk_eq("rst_error", error, 0);
        chk_eq("rst_started", started_cnt, 0);
        chk_eq("rst_total", total_cycles, 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Single transaction: ready at edge 2, done at edge 5; stray cmd at 3.
        run_batch(16'd1, 64'h4, 64'h20, 8, 3, start_hi, fin_cnt, fin_k);
        chk_eq("one_start_hi", start_hi, 2);
        chk_eq("one_fin_cnt", fin_cnt, 1);
        chk_eq("one_fin_k", fin_k, 5);
        chk_eq("one_started", started_cnt, 1);
        chk_eq("one_done", done_cnt, 1);
        chk_eq("one_first_lat", first_lat, 5);
        chk_eq("one_last_ii", last_ii, 0);
        chk_eq("one_total", total_cycles, 5);
        chk_eq("one_busy", busy, 0);

        // Pipelined: ready at 3,6,9,12; done at 13,16,19,22; stray cmd at 5.
        run_batch(16'd4, 64'h1248, 64'h492000, 26, 5, start_hi, fin_cnt, fin_k);
        chk_eq("pipe_start_hi", start_hi, 12);
        chk_eq("pipe_fin_cnt", fin_cnt, 1);
        chk_eq("pipe_fin_k", fin_k, 22);
        chk_eq("pipe_started", started_cnt, 4);
        chk_eq("pipe_done", done_cnt, 4);
        chk_eq("pipe_last_ii", last_ii, 3);
        chk_eq("pipe_first_lat", first_lat, 13);
        chk_eq("pipe_total", total_cycles, 22);

        // Same-cycle ready+done at edge 3; extra done at edge 5 after the end.
        run_batch(16'd2, 64'hA, 64'h38, 7, -1, start_hi, fin_cnt, fin_k);
        chk_eq("sim_start_hi", start_hi, 3);
        chk_eq("sim_fin_cnt", fin_cnt, 1);
        chk_eq("sim_fin_k", fin_k, 4);
        chk_eq("sim_started", started_cnt, 2);
        chk_eq("sim_done", done_cnt, 2);
        chk_eq("sim_first_lat", first_lat, 3);
        chk_eq("sim_last_ii", last_ii, 2);
        chk_eq("sim_total", total_cycles, 4);

        // Zero-length batch.
        cmd_valid = 1'b1;
        cmd_num   = 16'd0;
        @(negedge clock);
        cmd_valid = 1'b0;
        chk_eq("zero_finish", finish, 1);
        chk_eq("zero_busy", busy, 0);
        chk_eq("zero_ap_start", ap_start, 0);
        chk_eq("zero_cmd_ready", cmd_ready, 1);
        chk_eq("zero_total", total_cycles, 0);
        chk_eq("zero_started", started_cnt, 0);
        chk_eq("zero_done", done_cnt, 0);
        chk_eq("zero_first_lat", first_lat, 0);
        @(negedge clock);
        chk_eq("zero_finish_drop", finish, 0);

        // Watchdog: core never answers, ERR on edge TIMEOUT after accept.
        cmd_valid = 1'b1;
        cmd_num   = 16'd1;
        @(negedge clock);
        for (int k = 1; k < TIMEOUT; k++) begin
            cmd_valid = (k == 3);
            cmd_num   = (k == 3) ? 16'd5 : 16'd0;
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        chk_eq("wd_busy_before", busy, 1);
        chk_eq("wd_error_before", error, 0);
        @(negedge clock);
        chk_eq("wd_error", error, 1);
        chk_eq("wd_finish", finish, 1);
        chk_eq("wd_busy", busy, 0);
        chk_eq("wd_cmd_ready", cmd_ready, 0);
        chk_eq("wd_ap_start", ap_start, 0);
        chk_eq("wd_ap_continue", ap_continue, 0);
        chk_eq("wd_started", started_cnt, 0);
        @(negedge clock);
        chk_eq("wd_finish_drop", finish, 0);
        chk_eq("wd_error_sticky", error, 1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk_eq("clr_error", error, 0);
        chk_eq("clr_cmd_ready", cmd_ready, 1);
        chk_eq("clr_busy", busy, 0);

        // Mid-batch reset after two handshakes.
        cmd_valid = 1'b1;
        cmd_num   = 16'd4;
        @(negedge clock);
        cmd_valid = 1'b0;
        ap_ready  = 1'b1;
        repeat (2) @(negedge clock);
        ap_ready  = 1'b0;
        chk_eq("mid_started", started_cnt, 2);
        chk_eq("mid_ap_start_pre", ap_start, 1);
        reset = 1'b0;
        #2;
        chk_eq("mid_ap_start", ap_start, 0);
        chk_eq("mid_busy", busy, 0);
        chk_eq("mid_ap_continue", ap_continue, 0);
        chk_eq("mid_cmd_ready", cmd_ready, 1);
        chk_eq("mid_started_clr", started_cnt, 0);
        chk_eq("mid_finish", finish, 0);
        @(negedge clock);
        chk_eq("mid_finish_hold", finish, 0);
        @(negedge clock);
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_num   = 16'd1;
        @(negedge clock);
        chk_eq("rel_no_early_accept", busy, 0);
        for (int i = 0; i < 8 && !busy; i++) @(negedge clock);
        cmd_valid = 1'b0;
        chk_eq("rel_accept", busy, 1);
        ap_ready = 1'b1;
        for (int i = 0; i < 8 && started_cnt != 16'd1; i++) @(negedge clock);
        ap_ready = 1'b0;
        chk_eq("rel_started", started_cnt, 1);
        ap_done = 1'b1;
        @(negedge clock);
        ap_done = 1'b0;
        chk_eq("rel_finish", finish, 1);
        chk_eq("rel_done", done_cnt, 1);
        chk_eq("rel_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
